// File: rtl/bank_ram_arb.sv
// bank_ram_arb: round-robin arbiter from NUM_SLOTS command slots onto one
// banked RAM port. Writes wait in a command queue for their data; reads go
// straight to the port once the queue is empty, and are tagged so that the
// response comes back to the slot that asked for it.
module bank_ram_arb #(
  parameter int NUM_SLOTS  = 4,
  parameter int NUM_BANKS  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_SLOTS-1:0]                      s_cmd_valid,
  output logic [NUM_SLOTS-1:0]                      s_cmd_ready,
  input  logic [NUM_SLOTS-1:0]                      s_cmd_rw,
  input  logic [NUM_SLOTS*NUM_BANKS-1:0]            s_cmd_mask,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]           s_cmd_addr,
  input  logic [NUM_SLOTS-1:0]                      s_wvalid,
  output logic [NUM_SLOTS-1:0]                      s_wready,
  input  logic [NUM_SLOTS*NUM_BANKS*DATA_WIDTH-1:0] s_wdata,
  output logic [NUM_SLOTS-1:0]                      s_rvalid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]           s_rdata,
  output logic                                      phy_valid,
  input  logic                                      phy_ready,
  output logic                                      phy_rw,
  output logic [NUM_BANKS-1:0]                      phy_mask,
  output logic [ADDR_WIDTH-1:0]                     phy_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]           phy_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]           phy_rdata,
  output logic [$clog2(FIFO_DEPTH):0]               wq_level
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = NUM_BANKS * DATA_WIDTH;

  logic [NUM_BANKS-1:0]  mask_arr  [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_SLOTS];
  logic [BW-1:0]         wdata_arr [NUM_SLOTS];

  logic [SW-1:0]         last_grant_q, last_grant_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [SW-1:0]         fifo_src_q  [FIFO_DEPTH];
  logic [SW-1:0]         fifo_src_d  [FIFO_DEPTH];
  logic [NUM_BANKS-1:0]  fifo_mask_q [FIFO_DEPTH];
  logic [NUM_BANKS-1:0]  fifo_mask_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [SW-1:0]         tag_src_q [RD_LATENCY];
  logic [SW-1:0]         tag_src_d [RD_LATENCY];

  logic          win_found, win_rw, win_ready;
  logic [SW-1:0] winner, head_src;
  logic          empty, full, wr_issue, cmd_accept, push, rd_accept;

  // Split the flat per-slot buses into slot-indexed arrays.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      mask_arr[i]  = s_cmd_mask[i*NUM_BANKS +: NUM_BANKS];
      addr_arr[i]  = s_cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = s_wdata[i*BW +: BW];
    end
  end

  // Round-robin search: first valid slot above the last accepted one.
  always_comb begin : arb_search
    int unsigned   idx;
    logic [SW-1:0] cand;
    win_found = 1'b0;
    winner    = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_SLOTS; k++) begin
      idx  = (32'(last_grant_q) + k) % NUM_SLOTS;
      cand = SW'(idx);
      if (!win_found && s_cmd_valid[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  // Acceptance and issue decisions; reset gates every handshake.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(FIFO_DEPTH));
    head_src   = fifo_src_q[rd_ptr_q];
    win_rw     = s_cmd_rw[winner];
    win_ready  = win_rw ? !full : (empty && phy_ready);
    wr_issue   = !rst && !empty && s_wvalid[head_src] && phy_ready;
    cmd_accept = !rst && win_found && win_ready;
    push       = cmd_accept && win_rw;
    rd_accept  = cmd_accept && !win_rw;
  end

  // Slot handshakes and the physical command; a queued write outranks a read.
  always_comb begin
    s_cmd_ready = '0;
    s_wready    = '0;
    phy_valid   = 1'b0;
    phy_rw      = 1'b0;
    phy_mask    = '0;
    phy_addr    = '0;
    phy_wdata   = '0;
    if (cmd_accept) s_cmd_ready[winner] = 1'b1;
    if (wr_issue) begin
      s_wready[head_src] = 1'b1;
      phy_valid = 1'b1;
      phy_rw    = 1'b1;
      phy_mask  = fifo_mask_q[rd_ptr_q];
      phy_addr  = fifo_addr_q[rd_ptr_q];
      phy_wdata = wdata_arr[head_src];
    end else if (rd_accept) begin
      phy_valid = 1'b1;
      phy_mask  = mask_arr[winner];
      phy_addr  = addr_arr[winner];
    end
  end

  // Read responses: route the final tag stage back to its slot.
  always_comb begin
    s_rvalid = '0;
    if (tag_vld_q[RD_LATENCY-1]) s_rvalid[tag_src_q[RD_LATENCY-1]] = 1'b1;
    s_rdata  = phy_rdata;
    wq_level = count_q;
  end

  // Next-state for grant pointer, write queue and read tag pipeline.
  always_comb begin
    last_grant_d = cmd_accept ? winner : last_grant_q;
    wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = wr_issue ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(wr_issue);
    fifo_src_d   = fifo_src_q;
    fifo_mask_d  = fifo_mask_q;
    fifo_addr_d  = fifo_addr_q;
    if (push) begin
      fifo_src_d[wr_ptr_q]  = winner;
      fifo_mask_d[wr_ptr_q] = mask_arr[winner];
      fifo_addr_d[wr_ptr_q] = addr_arr[winner];
    end
    tag_vld_d    = '0;
    tag_vld_d[0] = rd_accept;
    tag_src_d    = tag_src_q;
    tag_src_d[0] = winner;
    for (int unsigned j = 1; j < RD_LATENCY; j++) begin
      tag_vld_d[j] = tag_vld_q[j-1];
      tag_src_d[j] = tag_src_q[j-1];
    end
  end

  // State registers; reset empties the queue and drops in-flight read tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= SW'(NUM_SLOTS - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fifo_src_q   <= '{default: '0};
      fifo_mask_q  <= '{default: '0};
      fifo_addr_q  <= '{default: '0};
      tag_vld_q    <= '0;
      tag_src_q    <= '{default: '0};
    end else begin
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_src_q   <= fifo_src_d;
      fifo_mask_q  <= fifo_mask_d;
      fifo_addr_q  <= fifo_addr_d;
      tag_vld_q    <= tag_vld_d;
      tag_src_q    <= tag_src_d;
    end
  end

endmodule

// File: doc/bank_ram_arb.md
BANK_RAM_ARB -- requirements
Module: bank_ram_arb

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of requesting slots, legal range 2..8.
REQ-002 SHALL have parameter NUM_BANKS, default 5: number of banks, and also the width of the mask.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data bits per bank.
REQ-004 SHALL have parameter ADDR_WIDTH, default 9: address bits.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: write-command queue depth, a power of 2 and at least 2.
REQ-006 SHALL have parameter RD_LATENCY, default 1: fixed number of cycles from read acceptance to phy_rdata valid, legal range 1..4.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port s_cmd_valid, input, NUM_SLOTS bits: per-slot command request.
REQ-010 SHALL have port s_cmd_ready, output, NUM_SLOTS bits: per-slot command accept.
REQ-011 SHALL have port s_cmd_rw, input, NUM_SLOTS bits: 1 = write, 0 = read.
REQ-012 SHALL have port s_cmd_mask, input, NUM_SLOTS*NUM_BANKS bits: per-slot bank enable.
REQ-013 SHALL have port s_cmd_addr, input, NUM_SLOTS*ADDR_WIDTH bits: per-slot address.
REQ-014 SHALL have port s_wvalid, input, NUM_SLOTS bits: per-slot write data valid.
REQ-015 SHALL have port s_wready, output, NUM_SLOTS bits: per-slot write data accept.
REQ-016 SHALL have port s_wdata, input, NUM_SLOTS*NUM_BANKS*DATA_WIDTH bits: per-slot write data.
REQ-017 SHALL have port s_rvalid, output, NUM_SLOTS bits: read data valid, asserted only toward the slot that issued the read.
REQ-018 SHALL have port s_rdata, output, NUM_BANKS*DATA_WIDTH bits: read data, broadcast to all slots and equal to phy_rdata.
REQ-019 SHALL have port phy_valid, output, 1 bit: physical command valid.
REQ-020 SHALL have port phy_ready, input, 1 bit: physical command accept.
REQ-021 SHALL have port phy_rw, output, 1 bit: physical direction, 1 = write.
REQ-022 SHALL have port phy_mask, output, NUM_BANKS bits: physical bank enable.
REQ-023 SHALL have port phy_addr, output, ADDR_WIDTH bits: physical address.
REQ-024 SHALL have port phy_wdata, output, NUM_BANKS*DATA_WIDTH bits: physical write data.
REQ-025 SHALL have port phy_rdata, input, NUM_BANKS*DATA_WIDTH bits: physical read data.
REQ-026 SHALL have port wq_level, output, $clog2(FIFO_DEPTH)+1 bits: write-queue occupancy.

Function
REQ-027 Arbitration SHALL be round-robin.
- The winner is the first slot with s_cmd_valid set, searching upward from last_grant+1 and wrapping modulo NUM_SLOTS.
- last_grant SHALL update to the winner only on the cycle that slot's command is accepted; a blocked winner keeps its grant.
REQ-028 Only the winner SHALL see s_cmd_ready=1; a blocked winner SHALL NOT be bypassed by any other slot in the same cycle.
REQ-029 Write command acceptance:
- s_cmd_ready = !full.
- On accept, {src_id, mask, addr} SHALL be pushed into the write queue.
- A full queue SHALL block the push even if a pop occurs in the same cycle.
REQ-030 Read command acceptance:
- s_cmd_ready = queue empty && phy_ready, which gives read-after-write ordering.
- On accept, phy_valid=1 and phy_rw=0, with the winner's mask and addr, in the same cycle (combinational).
REQ-031 Write issue:
- Occurs when the queue is non-empty, s_wvalid[head.src_id]=1 and phy_ready=1.
- That cycle: phy_valid=1, phy_rw=1, head mask/addr, phy_wdata = s_wdata of head.src_id, s_wready[head.src_id]=1, queue pop.
REQ-032 Write issue SHALL have priority over read issue; phy_valid SHALL assert at most once per cycle.
REQ-033 When there is no issue, phy_valid, phy_rw, phy_mask, phy_addr and phy_wdata SHALL all be 0.
REQ-034 Simultaneous push and pop on a non-full queue SHALL leave wq_level unchanged; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 Read tag pipeline:
- A RD_LATENCY-stage shift register of {valid, src_id}.
- Stage 0 loads on each read acceptance.
- s_rvalid[i] = last stage valid && src_id==i; s_rdata = phy_rdata (combinational).
REQ-036 Back-to-back reads on consecutive cycles SHALL return tagged responses on consecutive cycles with no bubbles.
REQ-037 Writes SHALL never generate s_rvalid.

Reset
REQ-038 While rst=1, and at its asynchronous assertion:
- Write queue empty, wq_level=0, tag pipeline cleared, last_grant=NUM_SLOTS-1.
- Therefore s_cmd_ready=0, s_wready=0, s_rvalid=0 and phy_valid=0.
REQ-039 Asserting rst mid-operation SHALL discard all queued writes and all in-flight read tags; no response SHALL emerge after release.

Verification
REQ-040 Fairness: slots 0-3 all hold read valid, phy_ready=1 -> grants 0,1,2,3,0 on five consecutive cycles.
REQ-041 Read tag routing: RD_LATENCY=2, slot 2 read accepted at cycle t -> s_rvalid=4'b0100 at cycle t+2, s_rdata=phy_rdata.
REQ-042 Write queue full:
- Slot 1 issues 4 writes with s_wvalid=0 -> wq_level=4.
- Fifth write sees s_cmd_ready=0.
- s_wvalid[1]=1 -> one pop per cycle, level counts down 4,3,2,1,0.
REQ-043 Ordering: slot 0 write queued with slot 0 wdata withheld, slot 3 read pending -> read is blocked until the write issues, then the read issues the following cycle.
REQ-044 Backpressure: phy_ready=0 with a write at the queue head and s_wvalid=1 -> s_wready=0 and no pop; phy_ready=1 -> issue in that cycle.
REQ-045 Reset mid-flight: rst pulsed with wq_level=3 and a read tag in flight -> wq_level=0 and no s_rvalid ever appears.
